// File: rtl/ipf_lcu_sequencer_pkg.sv
// Shared definitions for the IPF front-end: state encoding, LCU size
// lookups, parameter word layout and the pixel address concatenation.
package ipf_pkg;

    localparam int ADDR_W = 14;
    localparam int PRM_AW = 6;
    localparam int PRM_W  = 24;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_PFETCH = 3'd1,
        ST_STREAM = 3'd2,
        ST_FLUSH  = 3'd3,
        ST_DONE   = 3'd4
    } seq_state_t;

    localparam logic [1:0] SZ_16 = 2'd0;
    localparam logic [1:0] SZ_32 = 2'd1;
    localparam logic [1:0] SZ_64 = 2'd2;

    // Parameter word fields: [23:22] type, [21:17] band_pos, [16] wo_class, [15:0] offset
    localparam int PRM_TYPE_LSB = 22;
    localparam int PRM_BAND_LSB = 17;
    localparam int PRM_WO_BIT   = 16;
    localparam int PRM_OFS_LSB  = 0;

    // Encoding 3 is an alias of 64x64.
    function automatic logic [1:0] size_norm(input logic [1:0] cfg);
        return (cfg == 2'd3) ? SZ_64 : cfg;
    endfunction

    // LCU width minus one (16/32/64).
    function automatic logic [5:0] lcu_w_m1(input logic [1:0] sz);
        case (sz)
            SZ_16:   return 6'd15;
            SZ_32:   return 6'd31;
            default: return 6'd63;
        endcase
    endfunction

    // LCUs per row minus one (8/4/2).
    function automatic logic [2:0] lcus_per_row_m1(input logic [1:0] sz);
        case (sz)
            SZ_16:   return 3'd7;
            SZ_32:   return 3'd3;
            default: return 3'd1;
        endcase
    endfunction

    // Raster address of pixel (col,row) inside LCU (x,y) of a 128-wide image.
    function automatic logic [ADDR_W-1:0] addr_concat(input logic [1:0] sz,
                                                      input logic [2:0] y,
                                                      input logic [5:0] row,
                                                      input logic [2:0] x,
                                                      input logic [5:0] col);
        case (sz)
            SZ_16:   return {y[2:0], row[3:0], x[2:0], col[3:0]};
            SZ_32:   return {y[1:0], row[4:0], x[1:0], col[4:0]};
            default: return {y[0], row[5:0], x[0], col[5:0]};
        endcase
    endfunction

    // Parameter table index y*lcus_per_row + x.
    function automatic logic [PRM_AW-1:0] prm_index(input logic [1:0] sz,
                                                    input logic [2:0] y,
                                                    input logic [2:0] x);
        case (sz)
            SZ_16:   return {y[2:0], x[2:0]};
            SZ_32:   return {2'b00, y[1:0], x[1:0]};
            default: return {4'b0000, y[0], x[0]};
        endcase
    endfunction

endpackage

// File: rtl/ipf_lcu_sequencer_if.sv
// Pixel memory and parameter table read ports of the sequencer.
// Handshake: a read is requested by holding *_ren high with *_addr for one
// cycle; *_rdata is valid exactly one cycle later. There is no backpressure.
interface ipf_lcu_sequencer_if;
    import ipf_pkg::*;

    logic [ADDR_W-1:0] pix_addr;
    logic              pix_ren;
    logic [7:0]        pix_rdata;
    logic [PRM_AW-1:0] prm_addr;
    logic              prm_ren;
    logic [PRM_W-1:0]  prm_rdata;

    modport master (output pix_addr, pix_ren, prm_addr, prm_ren,
                    input  pix_rdata, prm_rdata);
    modport slave  (input  pix_addr, pix_ren, prm_addr, prm_ren,
                    output pix_rdata, prm_rdata);
endinterface

// File: rtl/ipf_lcu_sequencer_addr_gen.sv
// col/row/lcu_x/lcu_y counter chain producing the LCU-order pixel address,
// LCU/image boundary flags and the coordinates/index of the following LCU.
module ipf_lcu_addr_gen
    import ipf_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              clr,
    input  logic              adv,
    input  logic [1:0]        sz,
    output logic [ADDR_W-1:0] pix_addr,
    output logic              first_lcu_pix,
    output logic              last_lcu_pix,
    output logic              last_img_pix,
    output logic              last_lcu,
    output logic [2:0]        nxt_x,
    output logic [2:0]        nxt_y,
    output logic [PRM_AW-1:0] nxt_prm_idx
);

    logic [5:0] col_q, col_d, row_q, row_d;
    logic [2:0] lx_q, lx_d, ly_q, ly_d;
    logic       col_last, row_last, x_last, y_last;

    assign col_last      = (col_q == lcu_w_m1(sz));
    assign row_last      = (row_q == lcu_w_m1(sz));
    assign x_last        = (lx_q == lcus_per_row_m1(sz));
    assign y_last        = (ly_q == lcus_per_row_m1(sz));
    assign first_lcu_pix = (col_q == 6'd0) && (row_q == 6'd0);
    assign last_lcu_pix  = col_last && row_last;
    assign last_lcu      = x_last && y_last;
    assign last_img_pix  = last_lcu_pix && last_lcu;
    assign pix_addr      = addr_concat(sz, ly_q, row_q, lx_q, col_q);
    assign nxt_x         = x_last ? 3'd0 : lx_q + 3'd1;
    assign nxt_y         = x_last ? ly_q + 3'd1 : ly_q;
    assign nxt_prm_idx   = prm_index(sz, nxt_y, nxt_x);

    // Ripple the counters: col fastest, then row, lcu_x, lcu_y.
    always_comb begin
        col_d = col_q;
        row_d = row_q;
        lx_d  = lx_q;
        ly_d  = ly_q;
        if (clr) begin
            col_d = 6'd0;
            row_d = 6'd0;
            lx_d  = 3'd0;
            ly_d  = 3'd0;
        end else if (adv) begin
            if (!col_last) begin
                col_d = col_q + 6'd1;
            end else begin
                col_d = 6'd0;
                if (!row_last) begin
                    row_d = row_q + 6'd1;
                end else begin
                    row_d = 6'd0;
                    if (!x_last) begin
                        lx_d = lx_q + 3'd1;
                    end else begin
                        lx_d = 3'd0;
                        ly_d = y_last ? 3'd0 : ly_q + 3'd1;
                    end
                end
            end
        end
    end

    // Counter registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            col_q <= 6'd0;
            row_q <= 6'd0;
            lx_q  <= 3'd0;
            ly_q  <= 3'd0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
            lx_q  <= lx_d;
            ly_q  <= ly_d;
        end
    end

endmodule

// File: rtl/ipf_lcu_sequencer.sv
// Streams a 128x128 image in LCU raster order into the IPF, gap-free, and
// presents each LCU's filter parameters aligned to the IPF end-of-LCU capture.
module ipf_lcu_sequencer
    import ipf_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [1:0]          cfg_lcu_size,
    input  logic                ipf_busy,
    ipf_lcu_sequencer_if.master mem,
    output logic                in_en,
    output logic [7:0]          din,
    output logic [1:0]          ipf_type,
    output logic [4:0]          ipf_band_pos,
    output logic                ipf_wo_class,
    output logic [15:0]         ipf_offset,
    output logic [2:0]          lcu_x,
    output logic [2:0]          lcu_y,
    output logic [1:0]          lcu_size,
    output logic                seq_busy,
    output logic                done,
    output logic [2:0]          dbg_state
);

    seq_state_t state_q, state_d;
    logic       flush_q, flush_d;
    logic [1:0] size_q, size_d;
    logic [1:0] sz_eff;

    logic              pix_ren, prm_ren, gen_clr, gen_adv;
    logic [PRM_AW-1:0] prm_addr;
    logic [ADDR_W-1:0] gen_addr;
    logic              first_lcu_pix, last_lcu_pix, last_img_pix, last_lcu;
    logic [2:0]        gen_nxt_x, gen_nxt_y;
    logic [PRM_AW-1:0] gen_nxt_idx;

    // Two-stage pixel pipeline: memory read, then din register.
    logic             ren_d1_q, ren_d1_d, lcu_end_d1_q, lcu_end_d1_d;
    logic             img_end_d1_q, img_end_d1_d, in_en_q, in_en_d;
    logic [7:0]       din_q, din_d;
    // Parameter path: LCU 0 captured straight to outputs, later LCUs via nxt.
    logic             pf0_pend_q, pf0_pend_d, prm_pend_q, prm_pend_d;
    logic [PRM_W-1:0] nxt_prm_q, nxt_prm_d, cur_prm_q, cur_prm_d;
    logic [2:0]       nxt_x_q, nxt_x_d, nxt_y_q, nxt_y_d;
    logic [2:0]       cur_x_q, cur_x_d, cur_y_q, cur_y_d;

    assign sz_eff = size_norm(size_q);

    ipf_lcu_addr_gen u_addr_gen (
        .clk           (clk),
        .reset         (reset),
        .clr           (gen_clr),
        .adv           (gen_adv),
        .sz            (sz_eff),
        .pix_addr      (gen_addr),
        .first_lcu_pix (first_lcu_pix),
        .last_lcu_pix  (last_lcu_pix),
        .last_img_pix  (last_img_pix),
        .last_lcu      (last_lcu),
        .nxt_x         (gen_nxt_x),
        .nxt_y         (gen_nxt_y),
        .nxt_prm_idx   (gen_nxt_idx)
    );

    // Sequencer FSM: next state and memory read strobes.
    always_comb begin
        state_d  = state_q;
        flush_d  = 1'b0;
        size_d   = size_q;
        pix_ren  = 1'b0;
        prm_ren  = 1'b0;
        prm_addr = '0;
        gen_clr  = 1'b0;
        gen_adv  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start && !ipf_busy) begin
                    state_d = ST_PFETCH;
                    size_d  = cfg_lcu_size;
                    gen_clr = 1'b1;
                end
            end
            ST_PFETCH: begin
                prm_ren  = 1'b1;
                state_d  = ST_STREAM;
            end
            ST_STREAM: begin
                pix_ren = 1'b1;
                gen_adv = 1'b1;
                // Prefetch the next LCU's word on the first pixel of this one.
                if (first_lcu_pix && !last_lcu) begin
                    prm_ren  = 1'b1;
                    prm_addr = gen_nxt_idx;
                end
                if (last_img_pix) begin
                    state_d = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                flush_d = !flush_q;
                if (flush_q) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Pixel and parameter pipeline next values.
    always_comb begin
        ren_d1_d     = pix_ren;
        lcu_end_d1_d = pix_ren && last_lcu_pix;
        img_end_d1_d = pix_ren && last_img_pix;
        in_en_d      = ren_d1_q;
        din_d        = ren_d1_q ? mem.pix_rdata : din_q;
        pf0_pend_d   = (state_q == ST_PFETCH);
        prm_pend_d   = prm_ren && (state_q == ST_STREAM);
        nxt_prm_d    = prm_pend_q ? mem.prm_rdata : nxt_prm_q;
        nxt_x_d      = prm_pend_d ? gen_nxt_x : nxt_x_q;
        nxt_y_d      = prm_pend_d ? gen_nxt_y : nxt_y_q;
        cur_prm_d    = cur_prm_q;
        cur_x_d      = cur_x_q;
        cur_y_d      = cur_y_q;
        if (pf0_pend_q) begin
            cur_prm_d = mem.prm_rdata;
            cur_x_d   = 3'd0;
            cur_y_d   = 3'd0;
        end else if (lcu_end_d1_q && !img_end_d1_q) begin
            // Switch on the edge that presents this LCU's last pixel.
            cur_prm_d = nxt_prm_q;
            cur_x_d   = nxt_x_q;
            cur_y_d   = nxt_y_q;
        end
    end

    // State and pipeline registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            flush_q      <= 1'b0;
            size_q       <= 2'd0;
            ren_d1_q     <= 1'b0;
            lcu_end_d1_q <= 1'b0;
            img_end_d1_q <= 1'b0;
            in_en_q      <= 1'b0;
            din_q        <= 8'd0;
            pf0_pend_q   <= 1'b0;
            prm_pend_q   <= 1'b0;
            nxt_prm_q    <= '0;
            nxt_x_q      <= 3'd0;
            nxt_y_q      <= 3'd0;
            cur_prm_q    <= '0;
            cur_x_q      <= 3'd0;
            cur_y_q      <= 3'd0;
        end else begin
            state_q      <= state_d;
            flush_q      <= flush_d;
            size_q       <= size_d;
            ren_d1_q     <= ren_d1_d;
            lcu_end_d1_q <= lcu_end_d1_d;
            img_end_d1_q <= img_end_d1_d;
            in_en_q      <= in_en_d;
            din_q        <= din_d;
            pf0_pend_q   <= pf0_pend_d;
            prm_pend_q   <= prm_pend_d;
            nxt_prm_q    <= nxt_prm_d;
            nxt_x_q      <= nxt_x_d;
            nxt_y_q      <= nxt_y_d;
            cur_prm_q    <= cur_prm_d;
            cur_x_q      <= cur_x_d;
            cur_y_q      <= cur_y_d;
        end
    end

    assign mem.pix_addr = gen_addr;
    assign mem.pix_ren  = pix_ren;
    assign mem.prm_addr = prm_addr;
    assign mem.prm_ren  = prm_ren;

    assign in_en        = in_en_q;
    assign din          = din_q;
    assign ipf_type     = cur_prm_q[PRM_TYPE_LSB +: 2];
    assign ipf_band_pos = cur_prm_q[PRM_BAND_LSB +: 5];
    assign ipf_wo_class = cur_prm_q[PRM_WO_BIT];
    assign ipf_offset   = cur_prm_q[PRM_OFS_LSB +: 16];
    assign lcu_x        = cur_x_q;
    assign lcu_y        = cur_y_q;
    assign lcu_size     = size_q;
    assign seq_busy     = (state_q != ST_IDLE);
    assign done         = (state_q == ST_DONE);
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_ipf_lcu_sequencer.sv
// Bench for ipf_lcu_sequencer: random parameter tables and a pixel memory
// returning addr[7:0]^0x5A, checked against an arithmetic LCU-order model.
module tb_ipf_lcu_sequencer;
    import ipf_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic        start = 1'b0;
    logic [1:0]  cfg_lcu_size = 2'd0;
    logic        ipf_busy = 1'b0;
    logic        in_en, ipf_wo_class, seq_busy, done;
    logic [7:0]  din;
    logic [1:0]  ipf_type, lcu_size;
    logic [4:0]  ipf_band_pos;
    logic [15:0] ipf_offset;
    logic [2:0]  lcu_x, lcu_y, dbg_state;

    ipf_lcu_sequencer_if mem_if ();

    ipf_lcu_sequencer dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .cfg_lcu_size (cfg_lcu_size),
        .ipf_busy     (ipf_busy),
        .mem          (mem_if),
        .in_en        (in_en),
        .din          (din),
        .ipf_type     (ipf_type),
        .ipf_band_pos (ipf_band_pos),
        .ipf_wo_class (ipf_wo_class),
        .ipf_offset   (ipf_offset),
        .lcu_x        (lcu_x),
        .lcu_y        (lcu_y),
        .lcu_size     (lcu_size),
        .seq_busy     (seq_busy),
        .done         (done),
        .dbg_state    (dbg_state)
    );

    // Memories: one-cycle read latency.
    logic [23:0] prm_mem [64];
    always @(posedge clk) begin
        if (mem_if.pix_ren) mem_if.pix_rdata <= mem_if.pix_addr[7:0] ^ 8'h5A;
        if (mem_if.prm_ren) mem_if.prm_rdata <= prm_mem[mem_if.prm_addr];
    end

    // ---------------- scoreboard ----------------
    logic [13:0] exp_addr_q[$];
    logic [37:0] exp_pix_q[$];
    int total = 0;
    int bad = 0;
    int done_cnt = 0;
    int ren_cnt = 0;
    int run_len = 0;
    int since_ren = 100;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: walk LCUs in raster order, pixels in raster order inside each.
    task automatic push_model(input logic [1:0] cfg);
        int w, l, k, kp, addr;
        logic [7:0] px;
        logic [2:0] ex, ey;
        w = (cfg == 2'd0) ? 16 : (cfg == 2'd1) ? 32 : 64;
        l = 128 / w;
        for (int ly = 0; ly < l; ly++) begin
            for (int lx = 0; lx < l; lx++) begin
                k = ly * l + lx;
                for (int r = 0; r < w; r++) begin
                    for (int c = 0; c < w; c++) begin
                        addr = (ly * w + r) * 128 + lx * w + c;
                        exp_addr_q.push_back(addr[13:0]);
                        // The last pixel of an LCU already carries the next LCU's parameters.
                        kp = (r == w - 1 && c == w - 1 && k < l * l - 1) ? k + 1 : k;
                        px = addr[7:0] ^ 8'h5A;
                        ex = 3'(kp % l);
                        ey = 3'(kp / l);
                        exp_pix_q.push_back({px, prm_mem[kp], ex, ey});
                    end
                end
            end
        end
    endtask

    // Monitor: compare every issued read and every presented pixel.
    always @(negedge clk) begin
        if (!reset) begin
            run_len = 0;
        end else begin
            if (mem_if.pix_ren) begin
                ren_cnt++;
                since_ren = 0;
                if (exp_addr_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL pix_addr_extra: got 0x%0h, expected no read", mem_if.pix_addr);
                end else begin
                    check("pix_addr", mem_if.pix_addr, exp_addr_q.pop_front());
                end
            end else if (since_ren < 1000) begin
                since_ren++;
            end
            if (in_en) begin
                run_len++;
                if (exp_pix_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL din_extra: got 0x%0h, expected no pixel", din);
                end else begin
                    check("pixel_and_params",
                          {din, ipf_type, ipf_band_pos, ipf_wo_class, ipf_offset, lcu_x, lcu_y},
                          exp_pix_q.pop_front());
                end
            end else if (run_len > 0) begin
                check("in_en_run_length", run_len, 16384);
                run_len = 0;
            end
            if (done) begin
                done_cnt++;
                check("done_after_last_ren", since_ren, 3);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic fill_table(input bit fixed0);
        for (int i = 0; i < 64; i++) prm_mem[i] = 24'($urandom);
        if (fixed0) prm_mem[0] = 24'h4A1234;
    endtask

    task automatic issue_start(input logic [1:0] cfg);
        @(negedge clk);
        start = 1'b1;
        cfg_lcu_size = cfg;
        @(negedge clk);
        start = 1'b0;
        cfg_lcu_size = 2'($urandom);
    endtask

    task automatic run_image(input logic [1:0] cfg, input bit fixed0, input bit mid_start);
        int d0, n;
        fill_table(fixed0);
        push_model(cfg);
        d0 = done_cnt;
        issue_start(cfg);
        check("seq_busy_after_start", seq_busy, 1);
        check("lcu_size_latched", lcu_size, cfg);
        @(negedge clk);
        @(negedge clk);
        check("in_en_low_before_first", in_en, 0);
        check("lcu0_offset_early", ipf_offset, prm_mem[0][15:0]);
        check("lcu0_band_pos_early", ipf_band_pos, prm_mem[0][21:17]);
        @(negedge clk);
        check("in_en_first_rise", in_en, 1);
        if (mid_start) begin
            for (int i = 0; i < 1000; i++) begin
                @(negedge clk);
                ipf_busy = 1'($urandom);
            end
            start = 1'b1;
            cfg_lcu_size = 2'($urandom);
            @(negedge clk);
            start = 1'b0;
            ipf_busy = 1'b0;
        end
        n = 0;
        while (done_cnt == d0 && n < 20000) begin
            @(negedge clk);
            n++;
        end
        if (done_cnt == d0) begin
            total++;
            bad++;
            $display("FAIL done_timeout: got no done after %0d cycles, expected one", n);
        end
        repeat (3) @(negedge clk);
        check("done_pulse_count", done_cnt - d0, 1);
        check("seq_busy_idle_after", seq_busy, 0);
        check("scoreboard_drained", exp_addr_q.size() + exp_pix_q.size(), 0);
        exp_addr_q.delete();
        exp_pix_q.delete();
    endtask

    task automatic reset_mid(input logic [1:0] cfg);
        int n;
        fill_table(1'b0);
        push_model(cfg);
        ren_cnt = 0;
        issue_start(cfg);
        n = 0;
        while (ren_cnt < 5000 && n < 20000) begin
            @(negedge clk);
            n++;
        end
        check("reached_pixel_5000", ren_cnt, 5000);
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("abort_in_en", in_en, 0);
        check("abort_pix_ren", mem_if.pix_ren, 0);
        check("abort_done", done, 0);
        check("abort_seq_busy", seq_busy, 0);
        exp_addr_q.delete();
        exp_pix_q.delete();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        repeat (3) @(negedge clk);
        check("rst_in_en", in_en, 0);
        check("rst_done", done, 0);
        check("rst_seq_busy", seq_busy, 0);
        check("rst_pix_ren", mem_if.pix_ren, 0);
        check("rst_prm_ren", mem_if.prm_ren, 0);
        check("rst_pix_addr", mem_if.pix_addr, 0);
        check("rst_params", {ipf_type, ipf_band_pos, ipf_wo_class, ipf_offset, lcu_x, lcu_y}, 0);
        check("rst_lcu_size_din", {lcu_size, din}, 0);
        check("rst_state", dbg_state, 0);
        reset = 1'b1;
        @(negedge clk);

        // start while IPF busy is dropped
        ipf_busy = 1'b1;
        issue_start(2'd1);
        repeat (3) @(negedge clk);
        check("busy_start_seq_busy", seq_busy, 0);
        check("busy_start_state", dbg_state, 0);
        check("busy_start_no_read", {mem_if.pix_ren, mem_if.prm_ren}, 0);
        ipf_busy = 1'b0;

        run_image(2'd0, 1'b1, 1'b0);
        run_image(2'd2, 1'b0, 1'b0);
        run_image(2'd1, 1'b0, 1'b1);
        reset_mid(2'($urandom_range(0, 2)));
        run_image(2'd3, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global time bound.
    initial begin
        #1500000;
        $display("FAIL watchdog: got simulation still running, expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/ipf_lcu_sequencer.md
Name: ipf_lcu_sequencer

Overview:
Front-end controller that streams a 128x128 8-bit image from pixel memory into the IPF filter, in LCU raster order. For each LCU it fetches that LCU's filter parameters from a parameter table and presents them on the IPF parameter inputs, aligned to the IPF's end-of-LCU capture point. The IPF counters free-run, so the pixel stream must be gap-free. The sequencer guarantees one pixel per cycle from first to last pixel.

Parameters:
ADDR_W, 14, pixel memory address width (128x128 image)
PRM_AW, 6, parameter table address width (up to 64 LCUs)
PRM_W, 24, parameter word: [23:22] type, [21:17] band_pos, [16] wo_class, [15:0] offset

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
start  in  1  one-cycle request to process one image; ignored unless in IDLE
cfg_lcu_size  in  2  0=16, 1=32, 2=64; 3 treated as 64; sampled at accepted start
ipf_busy  in  1  IPF busy; start is not accepted while high
pix_addr  out  ADDR_W  pixel memory read address
pix_ren  out  1  pixel read enable
pix_rdata  in  8  read data, valid 1 cycle after pix_ren
prm_addr  out  PRM_AW  parameter table address, index = lcu_y*lcus_per_row + lcu_x
prm_ren  out  1  parameter read enable
prm_rdata  in  PRM_W  read data, valid 1 cycle after prm_ren
in_en  out  1  IPF input valid
din  out  8  IPF pixel
ipf_type  out  2  IPF parameter
ipf_band_pos  out  5  IPF parameter
ipf_wo_class  out  1  IPF parameter
ipf_offset  out  16  IPF parameter
lcu_x  out  3  IPF parameter
lcu_y  out  3  IPF parameter
lcu_size  out  2  registered copy of cfg_lcu_size
seq_busy  out  1  high from accepted start through done
done  out  1  one-cycle pulse after the last pixel

Behaviour:
- Reset values: all outputs 0; state IDLE; counters 0. Reset is honoured at any time, including mid-stream; after release the block is in IDLE with in_en=0.
- States:
  - IDLE: on start && !ipf_busy, latch size and go to PFETCH. start with ipf_busy high is dropped, not queued.
  - PFETCH: 1 cycle. prm_ren=1, prm_addr=0. Next state STREAM.
  - STREAM: pix_ren=1 every cycle. Captured prm_rdata loads the parameter outputs for LCU 0. Leave after the last address is issued.
  - FLUSH: 2 cycles, draining the in-flight pixels.
  - DONE: 1 cycle. done=1, then IDLE.
- Pixel address order:
  - Counters are col (fastest), row, lcu_x, lcu_y; each wraps at N-1, where N = LCU width (16/32/64) or LCUs per row (8/4/2).
  - pix_addr = {lcu_y, row, lcu_x, col}, truncated per size: size0 {y[2:0],row[3:0],x[2:0],col[3:0]}, size1 {y[1:0],row[4:0],x[1:0],col[4:0]}, size2 {y[0],row[5:0],x[0],col[5:0]}.
- Output timing:
  - din = pix_rdata registered. in_en first rises at the 3rd rising edge after the edge that accepted start.
  - in_en then stays high for exactly 16384 consecutive cycles. It is never deasserted mid-image, and ipf_busy is not sampled during streaming.
- Parameter prefetch:
  - For LCU k+1, prm_ren is issued while LCU k streams, at least 2 cycles before its last pixel, and the result is held in a next-parameter register.
  - All parameter outputs (including lcu_x, lcu_y) switch to LCU k+1 values on the same edge that presents LCU k's last pixel on din/in_en.
  - They then hold until the corresponding point of the next LCU. LCU 0 values are valid from the cycle before the first in_en.
  - After the last LCU, parameter outputs hold their final values until the next start.
- seq_busy = (state != IDLE).
- start during any non-IDLE state has no effect. cfg_lcu_size changes mid-image have no effect.

Decomposition:
- Shared package ipf_pkg:
  - state encoding constants
  - lcu_size encodings and the derived LCU_W and LCUS_PER_ROW lookup
  - field offsets of the parameter word
  - address concat function (shared with IPF's dout_addr generation)
- One natural sub-module, ipf_lcu_addr_gen: the col/row/lcu_x/lcu_y counter chain, producing pix_addr, the last-pixel-of-LCU flag, the last-pixel-of-image flag and the next prm index.

Test Plan:
- Size 0, table entry 0 = 0x4A_1234: start → in_en rises 3 cycles later. First pix_addr sequence 0,1,..,15,128. Pixel 16 of the stream is addr 128. ipf_offset=0x1234, ipf_band_pos=5 before the first in_en.
- Size 2, 4 distinct table entries: lcu_x/lcu_y sequence (0,0),(1,0),(0,1),(1,1). Each switches on the edge presenting the 4096th pixel of the prior LCU. in_en high 16384 cycles contiguous; done pulses 1 cycle, 3 cycles after the last pix_ren.
- ipf_busy=1 with start pulse → no state change, seq_busy stays 0. A later start with ipf_busy=0 is accepted.
- Second start pulse mid-stream (size 1) → no restart, address sequence unbroken, single done.
- reset low at pixel 5000 → in_en, pix_ren and done are 0 immediately. After release, a new start streams from address 0.
- Memory returns din = addr[7:0] ^ 0x5A: din sequence matches the expected LCU-order transform for all three sizes (scoreboard).
